// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: operation codes, memory
// write codes, read-cut selects, FSM state encoding and a decode helper.
package mem_access_unit_pkg;

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LHU = 4'd2;
  localparam logic [3:0] OP_LB  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_SW  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd7;
  localparam logic [3:0] OP_LL  = 4'd8;
  localparam logic [3:0] OP_SC  = 4'd9;

  localparam logic [2:0] WR_NONE   = 3'd0;
  localparam logic [2:0] WR_WORD   = 3'd1;
  localparam logic [2:0] WR_BYTE   = 3'd2;
  localparam logic [2:0] WR_ATOMIC = 3'd3;
  localparam logic [2:0] WR_HALF   = 3'd4;

  localparam logic [1:0] CUT_WORD = 2'd0;
  localparam logic [1:0] CUT_BYTE = 2'd1;
  localparam logic [1:0] CUT_HALF = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // True for every op whose response carries memory read data.
  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU) || (op == OP_LL);
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Turns the memory's cut read word into the 32-bit load result,
// applying sign or zero extension for half-word and byte loads.
module mem_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] dm,
  output logic [31:0] result
);

  // Pick the extension from the op; word loads pass the data through.
  always_comb begin
    result = dm;
    case (op)
      OP_LH:   result = {{16{dm[15]}}, dm[15:0]};
      OP_LHU:  result = {16'b0, dm[15:0]};
      OP_LB:   result = {{24{dm[7]}}, dm[7:0]};
      OP_LBU:  result = {24'b0, dm[7:0]};
      default: result = dm;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between EX and a big-endian, byte-addressed data memory.
// Accepts one op per handshake, drives the memory for a single ACCESS
// cycle, then returns one response in RESP. Defining LLSC_EN adds an
// LL/SC link register; without it ops LL and SC are reported as illegal.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Ad,
  output logic [DATA_W-1:0] WrData,
  output logic [2:0]        MemWr,
  output logic [1:0]        DMcut_sel,
  input  logic [DATA_W-1:0] DM
);

  state_e            state;
  logic [3:0]        op_q;
  logic              err_q;
  logic              sc_ok_q;
  logic [ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [2:0]        mem_wr_q;
  logic [1:0]        cut_q;

  logic              accept;
  logic              word_ok;
  logic              half_ok;
  logic              dec_err;
  logic              dec_sc_ok;
  logic [ADDR_W-1:0] dec_ad;
  logic [DATA_W-1:0] dec_wdata;
  logic [2:0]        dec_wr;
  logic [1:0]        dec_cut;
  logic [DATA_W-1:0] load_result;

`ifdef LLSC_EN
  logic              link_valid;
  logic [ADDR_W-3:0] link_addr;
  logic              link_hit;

  assign link_hit = link_valid && (link_addr == req_addr[ADDR_W-1:2]);
`endif

  assign req_ready = !Reset && ((state == ST_IDLE) || (state == ST_RESP));
  assign accept    = req_valid && req_ready;
  assign word_ok   = (req_addr[1:0] == 2'b00);
  assign half_ok   = !req_addr[0];

  // Decode the incoming request into the memory-side encoding and error flag.
  always_comb begin
    dec_err   = 1'b0;
    dec_sc_ok = 1'b0;
    dec_ad    = '0;
    dec_wdata = '0;
    dec_wr    = WR_NONE;
    dec_cut   = CUT_WORD;
    case (req_op)
      OP_LW: begin
        dec_err = !word_ok;
        dec_ad  = req_addr;
      end
      OP_LH, OP_LHU: begin
        dec_err = !half_ok;
        dec_ad  = req_addr - ADDR_W'(2);
        dec_cut = CUT_HALF;
      end
      OP_LB, OP_LBU: begin
        dec_ad  = req_addr - ADDR_W'(3);
        dec_cut = CUT_BYTE;
      end
      OP_SW: begin
        dec_err   = !word_ok;
        dec_ad    = req_addr;
        dec_wr    = WR_WORD;
        dec_wdata = req_wdata;
      end
      OP_SH: begin
        dec_err   = !half_ok;
        dec_ad    = req_addr - ADDR_W'(2);
        dec_wr    = WR_HALF;
        dec_wdata = {16'b0, req_wdata[15:0]};
      end
      OP_SB: begin
        dec_ad    = req_addr;
        dec_wr    = WR_BYTE;
        dec_wdata = {24'b0, req_wdata[7:0]};
      end
`ifdef LLSC_EN
      OP_LL: begin
        dec_err = !word_ok;
        dec_ad  = req_addr;
      end
      OP_SC: begin
        dec_err   = !word_ok;
        dec_ad    = req_addr;
        dec_sc_ok = link_hit;
        if (link_hit) begin
          dec_wr    = WR_ATOMIC;
          dec_wdata = req_wdata;
        end
      end
`endif
      default: dec_err = 1'b1;
    endcase
    if (dec_err) begin
      dec_sc_ok = 1'b0;
      dec_ad    = '0;
      dec_wdata = '0;
      dec_wr    = WR_NONE;
      dec_cut   = CUT_WORD;
    end
  end

  // Sequence IDLE/RESP -> ACCESS -> RESP, holding memory drive for ACCESS only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      err_q     <= 1'b0;
      sc_ok_q   <= 1'b0;
      ad_q      <= '0;
      wr_data_q <= '0;
      mem_wr_q  <= WR_NONE;
      cut_q     <= CUT_WORD;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            state     <= ST_ACCESS;
            op_q      <= req_op;
            err_q     <= dec_err;
            sc_ok_q   <= dec_sc_ok;
            ad_q      <= dec_ad;
            wr_data_q <= dec_wdata;
            mem_wr_q  <= dec_wr;
            cut_q     <= dec_cut;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state     <= ST_RESP;
          ad_q      <= '0;
          wr_data_q <= '0;
          mem_wr_q  <= WR_NONE;
          cut_q     <= CUT_WORD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LLSC_EN
  // Track the LL reservation; any completed store or SC to the word drops it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (accept && !dec_err) begin
      if (req_op == OP_LL) begin
        link_valid <= 1'b1;
        link_addr  <= req_addr[ADDR_W-1:2];
      end else if (req_op == OP_SC) begin
        link_valid <= 1'b0;
      end else if (((req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB)) && link_hit) begin
        link_valid <= 1'b0;
      end
    end
  end
`endif

  mem_load_extend u_load_extend (
    .op     (op_q),
    .dm     (DM),
    .result (load_result)
  );

  // A reset raised mid-access must not let the pending write reach memory.
  assign MemWr      = Reset ? WR_NONE : mem_wr_q;
  assign Ad         = ad_q;
  assign WrData     = wr_data_q;
  assign DMcut_sel  = cut_q;
  assign resp_valid = !Reset && (state == ST_RESP);
  assign resp_err   = resp_valid && err_q;

  // Build the response word from fresh memory data or the SC outcome.
  always_comb begin
    resp_data = '0;
    if (resp_valid && !err_q) begin
      if (is_load(op_q)) begin
        resp_data = load_result;
      end else if (op_q == OP_SC) begin
        resp_data = {31'b0, sc_ok_q};
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a behavioural big-endian byte
// memory answers the DUT, while a separate reference memory and link model
// predict each response from the op semantics.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [15:0] Ad;
  logic [31:0] WrData;
  logic [2:0]  MemWr;
  logic [1:0]  DMcut_sel;
  logic [31:0] DM = 32'h0;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0]  dutMem [int];
  logic [7:0]  refMem [int];
  logic [31:0] memWord;
  logic        linkValid;
  logic [13:0] linkWord;
  logic [31:0] lastData;
  logic [15:0] lastAd;
  logic [2:0]  lastWr;

`ifdef LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  mem_access_unit #(.ADDR_W(16), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .Ad(Ad), .WrData(WrData), .MemWr(MemWr), .DMcut_sel(DMcut_sel), .DM(DM)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] initByte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] dutRd(input logic [15:0] a);
    return dutMem.exists(int'(a)) ? dutMem[int'(a)] : initByte(a);
  endfunction

  function automatic logic [7:0] refRd(input logic [15:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : initByte(a);
  endfunction

  // Memory: registered read of bytes Ad..Ad+3 with cut, or a write.
  always @(posedge Clk) begin
    case (MemWr)
      3'd0: begin
        memWord = {dutRd(Ad), dutRd(16'(Ad + 16'd1)), dutRd(16'(Ad + 16'd2)), dutRd(16'(Ad + 16'd3))};
        case (DMcut_sel)
          2'd1:    DM <= {24'b0, memWord[7:0]};
          2'd2:    DM <= {16'b0, memWord[15:0]};
          default: DM <= memWord;
        endcase
      end
      3'd1, 3'd3: begin
        dutMem[int'(Ad)]                = WrData[31:24];
        dutMem[int'(16'(Ad + 16'd1))]   = WrData[23:16];
        dutMem[int'(16'(Ad + 16'd2))]   = WrData[15:8];
        dutMem[int'(16'(Ad + 16'd3))]   = WrData[7:0];
      end
      3'd2: dutMem[int'(Ad)] = WrData[7:0];
      3'd4: begin
        dutMem[int'(16'(Ad + 16'd2))] = WrData[15:8];
        dutMem[int'(16'(Ad + 16'd3))] = WrData[7:0];
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference semantics of one op: expected response, memory drive and state update.
  task automatic modelOp(input logic [3:0] op, input logic [15:0] a, input logic [31:0] wd,
                         output logic [31:0] eData, output logic eErr, output logic [2:0] eWr,
                         output logic [15:0] eAd, output logic [31:0] eWd, output logic [1:0] eCut);
    logic legal, needWord, needHalf, hit;
    logic [15:0] half;
    legal    = (op <= 4'd7) || (LLSC && op <= 4'd9);
    needWord = (op == 4'd0) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);
    needHalf = (op == 4'd1) || (op == 4'd2) || (op == 4'd6);
    eErr  = !legal || (needWord && a[1:0] != 2'b00) || (needHalf && a[0]);
    eData = 32'h0; eWr = 3'd0; eAd = 16'h0; eWd = 32'h0; eCut = 2'd0;
    hit   = linkValid && (linkWord == a[15:2]);
    if (!eErr) begin
      case (op)
        4'd0, 4'd8: begin
          eAd   = a;
          eData = {refRd(a), refRd(16'(a + 16'd1)), refRd(16'(a + 16'd2)), refRd(16'(a + 16'd3))};
          if (op == 4'd8) begin
            linkValid = 1'b1;
            linkWord  = a[15:2];
          end
        end
        4'd1, 4'd2: begin
          eAd   = a - 16'd2;
          eCut  = 2'd2;
          half  = {refRd(a), refRd(16'(a + 16'd1))};
          eData = (op == 4'd1) ? {{16{half[15]}}, half} : {16'b0, half};
        end
        4'd3, 4'd4: begin
          eAd   = a - 16'd3;
          eCut  = 2'd1;
          eData = (op == 4'd3) ? {{24{refRd(a) >= 8'h80}}, refRd(a)} : {24'b0, refRd(a)};
        end
        4'd5: begin
          eAd = a; eWr = 3'd1; eWd = wd;
          refMem[int'(a)] = wd[31:24];
          refMem[int'(16'(a + 16'd1))] = wd[23:16];
          refMem[int'(16'(a + 16'd2))] = wd[15:8];
          refMem[int'(16'(a + 16'd3))] = wd[7:0];
          if (hit) linkValid = 1'b0;
        end
        4'd6: begin
          eAd = a - 16'd2; eWr = 3'd4; eWd = {16'b0, wd[15:0]};
          refMem[int'(a)] = wd[15:8];
          refMem[int'(16'(a + 16'd1))] = wd[7:0];
          if (hit) linkValid = 1'b0;
        end
        4'd7: begin
          eAd = a; eWr = 3'd2; eWd = {24'b0, wd[7:0]};
          refMem[int'(a)] = wd[7:0];
          if (hit) linkValid = 1'b0;
        end
        default: begin
          eAd = a;
          linkValid = 1'b0;
          if (hit) begin
            eWr = 3'd3; eWd = wd; eData = 32'd1;
            refMem[int'(a)] = wd[31:24];
            refMem[int'(16'(a + 16'd1))] = wd[23:16];
            refMem[int'(16'(a + 16'd2))] = wd[15:8];
            refMem[int'(16'(a + 16'd3))] = wd[7:0];
          end
        end
      endcase
    end
  endtask

  // Issue one op from a ready cycle and check ACCESS and RESP against the model.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [31:0] wd);
    logic [31:0] eData, eWd;
    logic        eErr;
    logic [2:0]  eWr;
    logic [15:0] eAd;
    logic [1:0]  eCut;
    modelOp(op, a, wd, eData, eErr, eWr, eAd, eWd, eCut);
    checkOutput("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(negedge Clk);
    lastAd = Ad; lastWr = MemWr;
    checkOutput("acc_memwr", {29'b0, MemWr}, {29'b0, eWr});
    checkOutput("acc_ad", {16'b0, Ad}, {16'b0, eAd});
    checkOutput("acc_wrdata", WrData, eWd);
    checkOutput("acc_cut", {30'b0, DMcut_sel}, {30'b0, eCut});
    checkOutput("acc_nresp", {31'b0, resp_valid}, 32'd0);
    checkOutput("acc_nready", {31'b0, req_ready}, 32'd0);
    @(negedge Clk);
    lastData = resp_data;
    checkOutput("resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, eErr});
    checkOutput("resp_data", resp_data, eData);
    checkOutput("resp_memwr", {29'b0, MemWr}, 32'd0);
    checkOutput("resp_ad", {16'b0, Ad}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 16'h0; req_wdata = 32'h0;
    linkValid = 1'b0; linkWord = 14'h0;
    repeat (3) @(negedge Clk);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_resp", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_memwr", {29'b0, MemWr}, 32'd0);
    checkOutput("rst_ad", {16'b0, Ad}, 32'd0);
    Reset = 1'b0;
    #1;

    $display("[TB] directed word/half/byte accesses");
    applyStimulus(4'd5, 16'h0010, 32'h11223344);
    applyStimulus(4'd0, 16'h0010, 32'h0);
    checkOutput("t1_lw", lastData, 32'h11223344);
    applyStimulus(4'd6, 16'h0012, 32'hCAFE8001);
    applyStimulus(4'd1, 16'h0012, 32'h0);
    checkOutput("t2_lh", lastData, 32'hFFFF8001);
    checkOutput("t2_lh_ad", {16'b0, lastAd}, 32'h0010);
    applyStimulus(4'd2, 16'h0012, 32'h0);
    checkOutput("t2_lhu", lastData, 32'h00008001);
    applyStimulus(4'd7, 16'h0013, 32'h123456AB);
    checkOutput("t3_sb_wr", {29'b0, lastWr}, 32'd2);
    checkOutput("t3_sb_ad", {16'b0, lastAd}, 32'h0013);
    applyStimulus(4'd4, 16'h0013, 32'h0);
    checkOutput("t3_lbu", lastData, 32'h000000AB);
    checkOutput("t3_lbu_ad", {16'b0, lastAd}, 32'h0010);
    applyStimulus(4'd3, 16'h0013, 32'h0);
    checkOutput("t3_lb", lastData, 32'hFFFFFFAB);

    $display("[TB] errors and address wrap");
    applyStimulus(4'd0, 16'h0011, 32'h0);
    applyStimulus(4'd6, 16'h0013, 32'hFFFFFFFF);
    applyStimulus(4'd12, 16'h0010, 32'h0);
    applyStimulus(4'd3, 16'h0001, 32'h0);
    applyStimulus(4'd1, 16'h0000, 32'h0);
    checkOutput("wrap_lh_ad", {16'b0, lastAd}, 32'hFFFE);

    $display("[TB] LL/SC sequences");
    applyStimulus(4'd8, 16'h0020, 32'h0);
    applyStimulus(4'd9, 16'h0020, 32'hA5A5A5A5);
    checkOutput("sc_first", lastData, LLSC ? 32'd1 : 32'd0);
    applyStimulus(4'd8, 16'h0020, 32'h0);
    applyStimulus(4'd5, 16'h0020, 32'h01020304);
    applyStimulus(4'd9, 16'h0020, 32'h5A5A5A5A);
    checkOutput("sc_broken", lastData, 32'd0);
    applyStimulus(4'd0, 16'h0020, 32'h0);

    $display("[TB] reset during ACCESS of a store");
    req_valid = 1'b1; req_op = 4'd5; req_addr = 16'h0000; req_wdata = 32'hDEADBEEF;
    @(posedge Clk);
    #1 Reset = 1'b1; req_valid = 1'b0;
    @(negedge Clk);
    checkOutput("rstacc_memwr", {29'b0, MemWr}, 32'd0);
    checkOutput("rstacc_resp", {31'b0, resp_valid}, 32'd0);
    checkOutput("rstacc_ready", {31'b0, req_ready}, 32'd0);
    @(negedge Clk);
    checkOutput("rstpost_resp", {31'b0, resp_valid}, 32'd0);
    checkOutput("rstpost_memwr", {29'b0, MemWr}, 32'd0);
    Reset = 1'b0;
    linkValid = 1'b0;
    #1;
    applyStimulus(4'd0, 16'h0000, 32'h0);

    $display("[TB] randomized op stream");
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [3:0]  op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      else a = 16'(16'h0020 + 16'($urandom_range(0, 15)));
      applyStimulus(op, a, $urandom);
    end

    @(negedge Clk);
    checkOutput("end_idle_resp", {31'b0, resp_valid}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
